universal_shift_reg: RTL

Parametrised universal shift register: the next generation of the team's fixed 4-bit parallel-in/parallel-out register. One block covers all four shift-register styles (PIPO, SIPO, PISO, SISO) through a per-cycle mode select. It also adds serial ports at both ends and a shift counter with a done flag, so a serialiser can tell when a loaded word has been fully shifted out. It is the single storage/shift primitive for the serial-link and data-path exercises that follow.

---
 rtl/usr_pkg.sv | 32 +++
 rtl/usr_shift_counter.sv | 49 ++++
 rtl/universal_shift_reg.sv | 79 +++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// the mode type and a decode helper used by the top-level counter control.
// Optional feature macro: USR_ROTATE_EN (enables ROTL/ROTR modes).
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 3'b000;
  localparam usr_mode_t MODE_LOAD = 3'b001;
  localparam usr_mode_t MODE_SHL  = 3'b010;
  localparam usr_mode_t MODE_SHR  = 3'b011;
  localparam usr_mode_t MODE_ROTL = 3'b100;
  localparam usr_mode_t MODE_ROTR = 3'b101;

  // True for any mode that moves data and therefore advances the shift counter.
  // Rotates only count when the rotate feature is compiled in.
  function automatic logic mode_is_shift(input usr_mode_t m);
    logic r_is_shift;
    r_is_shift = 1'b0;
    case (m)
      MODE_SHL, MODE_SHR: r_is_shift = 1'b1;
`ifdef USR_ROTATE_EN
      MODE_ROTL, MODE_ROTR: r_is_shift = 1'b1;
`endif
      default: r_is_shift = 1'b0;
    endcase
    return r_is_shift;
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating shift counter with a registered done flag.
// Counts executed shifts since the last clear; done is high while the
// count equals WIDTH. Holding (inc low, clear low) freezes both outputs.
module usr_shift_counter #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat;

  assign w_sat = (r_cnt == CNT_MAX);

  // Next count: clear has priority, increments stop at WIDTH.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (inc && !w_sat) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Count and done flag registered together so done tracks shift_cnt exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign shift_cnt = r_cnt;
  assign done      = r_done;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, parallel load, shift left/right with
// serial inputs at both ends, optional rotates, plus a shift counter so a
// serialiser knows when a loaded word has been fully shifted out.
// Optional feature macro: USR_ROTATE_EN (modes 100/101 rotate; otherwise HOLD).
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  usr_mode_t        mode,
  input  logic [WIDTH-1:0] in,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  if (WIDTH < 2) begin : g_width_chk
    $error("universal_shift_reg: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_next;
  logic             w_load;
  logic             w_inc;

  // Data-path mode decode; unlisted and disabled modes keep the register.
  always_comb begin
    w_next = r_out;
    case (mode)
      MODE_HOLD: w_next = r_out;
      MODE_LOAD: w_next = in;
      MODE_SHL:  w_next = {r_out[WIDTH-2:0], ser_in_lsb};
      MODE_SHR:  w_next = {ser_in_msb, r_out[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      MODE_ROTL: w_next = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
      MODE_ROTR: w_next = {r_out[0], r_out[WIDTH-1:1]};
`else
      MODE_ROTL, MODE_ROTR: w_next = r_out;
`endif
      default:   w_next = r_out;
    endcase
  end

  // Counter control derived from the same mode decode.
  assign w_load = (mode == MODE_LOAD);
  assign w_inc  = mode_is_shift(mode);

  // Register storage; reset discards any partially shifted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  usr_shift_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_load),
    .inc       (w_inc),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  assign out         = r_out;
  assign ser_out_msb = r_out[WIDTH-1];
  assign ser_out_lsb = r_out[0];

endmodule
